// File: rtl/k12_pkg.sv
// k12 shared definitions: instruction classes, sequencer states and the
// LOAD target-select bit. Imported by the sequencer.
package k12_pkg;

  localparam logic [1:0] CLS_ALU  = 2'b00;
  localparam logic [1:0] CLS_LOAD = 2'b01;
  localparam logic [1:0] CLS_SKIP = 2'b10;
  localparam logic [1:0] CLS_OUT  = 2'b11;

  // payload bit choosing the LOAD destination: 0 -> X, 1 -> ACC
  localparam int LOAD_SEL_BIT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0]  cls;
    logic [13:0] pay;
  } inst_t;

endpackage

// File: rtl/k12_alu_seq.sv
// k12 instruction sequencer.
// Holds ACC, X and flag F, feeds the external combinational k12_alu with
// ACC/X/IR, writes back its result, handles conditional skip and streams
// ACC snapshots out.
// Ports:
//   clk, rst                 clock, async active-high reset
//   inst_valid/ready, inst   instruction handshake, 16-bit word
//   alu_a/alu_b/alu_inst     operands and op word to k12_alu
//   alu_res/alu_cond         result and condition from k12_alu
//   out_valid/ready, out_data  ACC snapshot stream
//   acc_q, flag_q, retired   architectural state / retire counter
module k12_alu_seq
  import k12_pkg::*;
#(
  parameter int         RETW      = 16,
  parameter logic [7:0] ACC_RESET = 8'h00
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_valid,
  output logic            inst_ready,
  input  logic [15:0]     inst,
  output logic [7:0]      alu_a,
  output logic [7:0]      alu_b,
  output logic [15:0]     alu_inst,
  input  logic [7:0]      alu_res,
  input  logic            alu_cond,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      out_data,
  output logic [7:0]      acc_q,
  output logic            flag_q,
  output logic [RETW-1:0] retired
);

  state_t          state, state_n;
  logic [7:0]      acc, acc_n, x, x_n, od, od_n;
  logic            f, f_n, skip, skip_n, ov, ov_n;
  logic [15:0]     ir, ir_n;
  logic [RETW-1:0] ret, ret_n;
  inst_t           di;
  logic            fire;

  assign di         = inst_t'(inst);
  assign inst_ready = (state == ST_IDLE);
  assign fire       = inst_valid & inst_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      acc   <= ACC_RESET;
      x     <= ACC_RESET;
      f     <= 1'b0;
      ir    <= '0;
      skip  <= 1'b0;
      ret   <= '0;
      ov    <= 1'b0;
      od    <= '0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      x     <= x_n;
      f     <= f_n;
      ir    <= ir_n;
      skip  <= skip_n;
      ret   <= ret_n;
      ov    <= ov_n;
      od    <= od_n;
    end
  end

  always_comb begin
    state_n = state;
    acc_n   = acc;
    x_n     = x;
    f_n     = f;
    ir_n    = ir;
    skip_n  = skip;
    ret_n   = ret;
    ov_n    = ov;
    od_n    = od;
    case (state)
      ST_IDLE: begin
        if (fire) begin
          if (skip) begin
            // shadowed instruction: swallowed without any side effect
            skip_n = 1'b0;
          end else begin
            case (di.cls)
              CLS_ALU: begin
                ir_n    = inst;
                state_n = ST_EXEC;
              end
              CLS_LOAD: begin
                if (di.pay[LOAD_SEL_BIT]) acc_n = di.pay[7:0];
                else                      x_n   = di.pay[7:0];
                ret_n = ret + RETW'(1);
              end
              CLS_SKIP: begin
                if (f) skip_n = 1'b1;
                ret_n = ret + RETW'(1);
              end
              default: begin  // CLS_OUT
                od_n    = acc;
                ov_n    = 1'b1;
                ret_n   = ret + RETW'(1);
                state_n = ST_OUT;
              end
            endcase
          end
        end
      end
      ST_EXEC: begin
        // single-cycle execute: ALU output settles from ACC/X/IR this cycle
        acc_n   = alu_res;
        f_n     = alu_cond;
        ret_n   = ret + RETW'(1);
        state_n = ST_IDLE;
      end
      ST_OUT: begin
        if (out_ready) begin
          ov_n    = 1'b0;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign alu_a     = acc;
  assign alu_b     = x;
  assign alu_inst  = {2'b00, ir[13:0]};
  assign out_valid = ov;
  assign out_data  = od;
  assign acc_q     = acc;
  assign flag_q    = f;
  assign retired   = ret;

endmodule

// File: tb/tb_k12_alu_seq.sv
module tb_k12_alu_seq;

  localparam int RETW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            inst_valid = 1'b0;
  logic            inst_ready;
  logic [15:0]     inst = '0;
  logic [7:0]      alu_a, alu_b;
  logic [15:0]     alu_inst;
  logic [7:0]      alu_res;
  logic            alu_cond;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [7:0]      out_data;
  logic [7:0]      acc_q;
  logic            flag_q;
  logic [RETW-1:0] retired;

  k12_alu_seq #(.RETW(RETW), .ACC_RESET(8'h00)) dut (
    .clk(clk), .rst(rst),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .alu_a(alu_a), .alu_b(alu_b), .alu_inst(alu_inst),
    .alu_res(alu_res), .alu_cond(alu_cond),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .acc_q(acc_q), .flag_q(flag_q), .retired(retired)
  );

  always #5 clk = ~clk;

  // ALU stand-in: either a fixed answer or a simple arithmetic function
  logic       fixed = 1'b1;
  logic [7:0] fix_res = 8'h5A;
  logic       fix_cond = 1'b1;

  function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [15:0] ins, input logic fx,
                                        input logic [7:0] fr, input logic fc);
    logic [7:0] r;
    if (fx) return {fc, fr};
    r = a ^ (b + ins[7:0]);
    return {r[7] ^ ins[13], r};
  endfunction

  always_comb {alu_cond, alu_res} = alu_fn(alu_a, alu_b, alu_inst, fixed, fix_res, fix_cond);

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
    end
  endtask

  // instruction-level reference model
  logic [7:0] m_acc, m_x;
  logic       m_f, m_skip;
  int         m_ret;

  task automatic model_reset();
    m_acc = 8'h00; m_x = 8'h00; m_f = 1'b0; m_skip = 1'b0; m_ret = 0;
  endtask

  task automatic send(input logic [15:0] i);
    int k = 0;
    inst = i;
    inst_valid = 1'b1;
    while (!inst_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) chk("send_timeout", 32'd1, 32'd0);
    @(negedge clk);
    inst_valid = 1'b0;
    inst = 16'($urandom);
  endtask

  // issue one instruction, follow it to completion, check against the model
  task automatic run_inst(input logic [15:0] i, input int rdly);
    logic [1:0] cls;
    logic       skipped;
    logic [8:0] r;
    cls = i[15:14];
    skipped = m_skip;
    send(i);
    if (skipped) begin
      m_skip = 1'b0;
    end else begin
      case (cls)
        2'b00: begin
          chk("exec_ready_low", 32'(inst_ready), 32'd0);
          chk("exec_alu_inst", 32'(alu_inst), 32'({2'b00, i[13:0]}));
          chk("exec_alu_a", 32'(alu_a), 32'(m_acc));
          chk("exec_alu_b", 32'(alu_b), 32'(m_x));
          r = alu_fn(m_acc, m_x, {2'b00, i[13:0]}, fixed, fix_res, fix_cond);
          m_acc = r[7:0];
          m_f = r[8];
          @(negedge clk);
        end
        2'b01: if (i[8]) m_acc = i[7:0]; else m_x = i[7:0];
        2'b10: if (m_f) m_skip = 1'b1;
        default: begin
          for (int c = 0; c < rdly; c++) begin
            chk("out_valid_hold", 32'(out_valid), 32'd1);
            chk("out_data_hold", 32'(out_data), 32'(m_acc));
            chk("out_ready_low", 32'(inst_ready), 32'd0);
            @(negedge clk);
          end
          chk("out_valid", 32'(out_valid), 32'd1);
          chk("out_data", 32'(out_data), 32'(m_acc));
          out_ready = 1'b1;
          @(negedge clk);
          out_ready = 1'b0;
          chk("out_valid_drop", 32'(out_valid), 32'd0);
        end
      endcase
      m_ret = (m_ret + 1) % (1 << RETW);
    end
    chk("idle_ready", 32'(inst_ready), 32'd1);
    chk("acc", 32'(acc_q), 32'(m_acc));
    chk("x", 32'(alu_b), 32'(m_x));
    chk("flag", 32'(flag_q), 32'(m_f));
    chk("retired", 32'(retired), 32'(m_ret));
  endtask

  typedef struct {
    logic [15:0] ins;
    int          rdly;
    logic [7:0]  e_acc;
    logic [7:0]  e_x;
    logic        e_f;
    logic [3:0]  e_ret;
  } vec_t;

  vec_t tbl[8];
  logic [3:0] r0;

  initial begin
    tbl[0] = '{16'h4112, 0, 8'h12, 8'h00, 1'b0, 4'd1};
    tbl[1] = '{16'h4034, 0, 8'h12, 8'h34, 1'b0, 4'd2};
    tbl[2] = '{16'h0A55, 0, 8'h5A, 8'h34, 1'b1, 4'd3};
    tbl[3] = '{16'h8000, 0, 8'h5A, 8'h34, 1'b1, 4'd4};
    tbl[4] = '{16'h41FF, 0, 8'h5A, 8'h34, 1'b1, 4'd4};
    tbl[5] = '{16'h4107, 0, 8'h07, 8'h34, 1'b1, 4'd5};
    tbl[6] = '{16'h41A5, 0, 8'hA5, 8'h34, 1'b1, 4'd6};
    tbl[7] = '{16'hC000, 3, 8'hA5, 8'h34, 1'b1, 4'd7};

    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_acc", 32'(acc_q), 32'h00);
    chk("rst_x", 32'(alu_b), 32'h00);
    chk("rst_f", 32'(flag_q), 32'd0);
    chk("rst_ret", 32'(retired), 32'd0);
    chk("rst_ready", 32'(inst_ready), 32'd1);
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_od", 32'(out_data), 32'h00);
    chk("rst_ir", 32'(alu_inst), 32'h0000);
    rst = 1'b0;
    @(negedge clk);

    // directed table: loads, ALU writeback, skip with F=1, held OUT
    for (int t = 0; t < 8; t++) begin
      run_inst(tbl[t].ins, tbl[t].rdly);
      chk("tbl_acc", 32'(acc_q), 32'(tbl[t].e_acc));
      chk("tbl_x", 32'(alu_b), 32'(tbl[t].e_x));
      chk("tbl_f", 32'(flag_q), 32'(tbl[t].e_f));
      chk("tbl_ret", 32'(retired), 32'(tbl[t].e_ret));
    end

    // skip sequence with F=0: nothing is shadowed
    fix_cond = 1'b0;
    run_inst(16'h0A55, 0);
    chk("f0_flag", 32'(flag_q), 32'd0);
    r0 = retired;
    run_inst(16'h8000, 0);
    run_inst(16'h41FF, 0);
    chk("f0_passes_ff", 32'(acc_q), 32'hFF);
    run_inst(16'h4107, 0);
    chk("f0_acc", 32'(acc_q), 32'h07);
    chk("f0_ret3", 32'(retired), 32'(r0 + 4'd3));

    // skip shadowing a SKIP: the second SKIP is eaten, next LOAD runs
    fix_cond = 1'b1;
    run_inst(16'h0A55, 0);
    run_inst(16'h8000, 0);
    run_inst(16'h8000, 0);
    run_inst(16'h4111, 0);
    chk("skipskip_acc", 32'(acc_q), 32'h11);

    // consecutive LOADs keep inst_ready high
    inst = 16'h4122; inst_valid = 1'b1;
    @(negedge clk);
    chk("b2b_ready", 32'(inst_ready), 32'd1);
    inst = 16'h4044;
    @(negedge clk);
    inst_valid = 1'b0;
    chk("b2b_acc", 32'(acc_q), 32'h22);
    chk("b2b_x", 32'(alu_b), 32'h44);
    m_acc = 8'h22; m_x = 8'h44; m_ret = (m_ret + 2) % 16;
    chk("b2b_ret", 32'(retired), 32'(m_ret));

    // randomized traffic against the model
    fixed = 1'b0;
    for (int n = 0; n < 300; n++)
      run_inst(16'($urandom), int'($urandom_range(0, 3)));
    fixed = 1'b1;

    // async reset mid-EXEC
    run_inst(16'h4133, 0);
    send(16'h0A55);
    chk("mid_exec_acc", 32'(acc_q), 32'h33);
    #2 rst = 1'b1;
    #1;
    chk("arst_acc", 32'(acc_q), 32'h00);
    chk("arst_f", 32'(flag_q), 32'd0);
    chk("arst_ready", 32'(inst_ready), 32'd1);
    chk("arst_ret", 32'(retired), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("post_rst_acc", 32'(acc_q), 32'h00);

    // async reset while an OUT is pending: out_valid drops before any edge
    run_inst(16'h4177, 0);
    send(16'hC000);
    chk("pre_rst_ov", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_ov", 32'(out_valid), 32'd0);
    chk("arst_od", 32'(out_data), 32'h00);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);

    // retire counter wrap
    for (int n = 0; n < 15; n++) run_inst(16'h4000 | 16'(n), 0);
    chk("ret_allones", 32'(retired), 32'hF);
    run_inst(16'h40AA, 0);
    chk("ret_wrap", 32'(retired), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
